// File: rtl/fire_dispatch_mc.sv
// Multi-lane fire dispatcher: queues synapse index ranges and splits
// them across per-lane iterators that issue one address per cycle.
module fire_dispatch_mc #(
    parameter int NUM_LANES   = 4,
    parameter int LANE_ADDR_W = 10,
    parameter int QUEUE_DEPTH = 4,
    localparam int IDX_W      = LANE_ADDR_W + $clog2(NUM_LANES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    output logic                             step_done,
    input  logic [IDX_W-1:0]                 syn_start,
    input  logic [IDX_W-1:0]                 syn_end,
    input  logic                             syn_in_vld,
    output logic                             syn_in_rdy,
    output logic                             range_err,
    output logic [NUM_LANES-1:0]             syn_vld,
    output logic [NUM_LANES*LANE_ADDR_W-1:0] syn_addr,
    input  logic [NUM_LANES-1:0]             syn_rdy
);

    localparam int LANE_W = $clog2(NUM_LANES);
    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QUEUE_DEPTH);

    // Range queue storage and pointers
    logic [IDX_W-1:0] q_start [QUEUE_DEPTH];
    logic [IDX_W-1:0] q_end   [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W:0]   count_next;

    logic q_empty;
    logic q_full;
    logic push;
    logic pop;

    // Head-of-queue decode
    logic [IDX_W-1:0]  head_start;
    logic [IDX_W-1:0]  head_end;
    logic              malformed;
    logic [LANE_W-1:0] lane_lo;
    logic [LANE_W-1:0] lane_hi;
    logic              span_ok;

    // Lane iterator state
    logic [NUM_LANES-1:0]   active;
    logic [LANE_ADDR_W-1:0] cur  [NUM_LANES];
    logic [LANE_ADDR_W-1:0] last [NUM_LANES];

    // Per-lane combinational status
    logic [NUM_LANES-1:0]   xfer;
    logic [NUM_LANES-1:0]   done;
    logic [NUM_LANES-1:0]   adv;
    logic [NUM_LANES-1:0]   free;
    logic [NUM_LANES-1:0]   in_span;
    logic [NUM_LANES-1:0]   load;
    logic [NUM_LANES-1:0]   active_next;
    logic [LANE_ADDR_W-1:0] ld_cur  [NUM_LANES];
    logic [LANE_ADDR_W-1:0] ld_last [NUM_LANES];

    logic idle_next;

    assign q_empty    = (count == '0);
    assign q_full     = (count == DEPTH_C);
    assign syn_in_rdy = enable & ~reset & ~q_full;
    assign push       = syn_in_vld & syn_in_rdy;

    assign head_start = q_start[rd_ptr];
    assign head_end   = q_end[rd_ptr];
    assign malformed  = head_start > head_end;
    assign lane_lo    = head_start[IDX_W-1:LANE_ADDR_W];
    assign lane_hi    = head_end[IDX_W-1:LANE_ADDR_W];

    // Lane status, pop decision and reload values
    always_comb begin
        xfer        = '0;
        done        = '0;
        adv         = '0;
        free        = '0;
        in_span     = '0;
        load        = '0;
        active_next = '0;
        span_ok     = 1'b1;
        pop         = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            ld_cur[k]  = '0;
            ld_last[k] = '1;
        end
        for (int k = 0; k < NUM_LANES; k++) begin
            xfer[k]    = syn_vld[k] & syn_rdy[k];
            done[k]    = xfer[k] & (cur[k] == last[k]);
            adv[k]     = xfer[k] & ~done[k];
            free[k]    = ~active[k] | done[k];
            in_span[k] = (LANE_W'(k) >= lane_lo) &&
                         (LANE_W'(k) <= lane_hi);
            if (in_span[k] && !free[k])
                span_ok = 1'b0;
        end
        pop = enable & ~q_empty & (malformed | span_ok);
        for (int k = 0; k < NUM_LANES; k++) begin
            load[k] = pop & ~malformed & in_span[k];
            // First touched lane starts mid-lane; last touched ends mid-lane
            if (LANE_W'(k) == lane_lo)
                ld_cur[k] = head_start[LANE_ADDR_W-1:0];
            if (LANE_W'(k) == lane_hi)
                ld_last[k] = head_end[LANE_ADDR_W-1:0];
            active_next[k] = load[k] | (active[k] & ~done[k]);
        end
    end

    assign count_next = count
                      + (PTR_W+1)'(push)
                      - (PTR_W+1)'(pop);
    assign idle_next  = (count_next == '0) &&
                        (active_next == '0) && !push;

    // Queue storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            q_start[wr_ptr] <= syn_start;
            q_end[wr_ptr]   <= syn_end;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end

    // Lane iterators: reload on pop, step on accepted transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= '0;
            for (int k = 0; k < NUM_LANES; k++) begin
                cur[k]  <= '0;
                last[k] <= '0;
            end
        end else begin
            active <= active_next;
            for (int k = 0; k < NUM_LANES; k++) begin
                if (load[k]) begin
                    cur[k]  <= ld_cur[k];
                    last[k] <= ld_last[k];
                end else if (adv[k]) begin
                    cur[k] <= cur[k] + 1'b1;
                end
            end
        end
    end

    // Status flags: malformed-drop pulse and registered idle indication
    always_ff @(posedge clk) begin
        if (reset) begin
            range_err <= 1'b0;
            step_done <= 1'b1;
        end else begin
            range_err <= pop & malformed;
            if (enable)
                step_done <= idle_next;
        end
    end

    // Lane outputs; valid is gated by the step enable
    always_comb begin
        syn_vld  = active & {NUM_LANES{enable}};
        syn_addr = '0;
        for (int k = 0; k < NUM_LANES; k++)
            syn_addr[k*LANE_ADDR_W +: LANE_ADDR_W] = cur[k];
    end

endmodule

// File: tb/tb_fire_dispatch_mc.sv
// Scoreboard bench for fire_dispatch_mc: stimulus pushes expected lane
// addresses; a negedge monitor pops and compares on every transfer.
module tb_fire_dispatch_mc;

    localparam int NL    = 4;
    localparam int LW    = 10;
    localparam int QD    = 4;
    localparam int IDX_W = LW + $clog2(NL);

    logic             clk;
    logic             reset;
    logic             enable;
    logic             step_done;
    logic [IDX_W-1:0] syn_start;
    logic [IDX_W-1:0] syn_end;
    logic             syn_in_vld;
    logic             syn_in_rdy;
    logic             range_err;
    logic [NL-1:0]    syn_vld;
    logic [NL*LW-1:0] syn_addr;
    logic [NL-1:0]    syn_rdy;

    int n_vec = 0;
    int n_err = 0;
    int exp_q [NL][$];
    int xfer_cnt [NL];
    logic [NL-1:0] prev_vld;
    logic [NL-1:0] prev_xfer;
    int prev_addr [NL];

    fire_dispatch_mc #(
        .NUM_LANES(NL),
        .LANE_ADDR_W(LW),
        .QUEUE_DEPTH(QD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .step_done(step_done),
        .syn_start(syn_start),
        .syn_end(syn_end),
        .syn_in_vld(syn_in_vld),
        .syn_in_rdy(syn_in_rdy),
        .range_err(range_err),
        .syn_vld(syn_vld),
        .syn_addr(syn_addr),
        .syn_rdy(syn_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int lane_addr(input int k);
        return int'(syn_addr[k*LW +: LW]);
    endfunction

    function automatic bit sb_empty();
        for (int k = 0; k < NL; k++)
            if (exp_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Monitor: compare each accepted lane address against the scoreboard
    initial begin
        prev_vld  = '0;
        prev_xfer = '0;
        for (int k = 0; k < NL; k++) begin
            xfer_cnt[k]  = 0;
            prev_addr[k] = 0;
        end
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_vld = '0;
            end else begin
                for (int k = 0; k < NL; k++) begin
                    if (prev_vld[k] && !prev_xfer[k] && syn_vld[k])
                        check($sformatf("stable_l%0d", k),
                              lane_addr(k), prev_addr[k]);
                    if (syn_vld[k] && syn_rdy[k]) begin
                        xfer_cnt[k]++;
                        if (exp_q[k].size() == 0) begin
                            check($sformatf("unexpected_l%0d", k),
                                  lane_addr(k), -1);
                        end else begin
                            check($sformatf("addr_l%0d", k),
                                  lane_addr(k), exp_q[k].pop_front());
                        end
                    end
                    prev_vld[k]  = syn_vld[k];
                    prev_xfer[k] = syn_vld[k] & syn_rdy[k];
                    prev_addr[k] = lane_addr(k);
                end
            end
        end
    end

    // Offer one range; on acceptance queue its expected lane addresses
    task automatic push_range(input int s, input int e);
        bit got;
        got        = 1'b0;
        syn_start  = IDX_W'(s);
        syn_end    = IDX_W'(e);
        syn_in_vld = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (syn_in_rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("push_timeout", 0, 1);
            syn_in_vld = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            syn_in_vld = 1'b0;
            for (int i = s; i <= e; i++)
                exp_q[i / (1 << LW)].push_back(i % (1 << LW));
        end
    endtask

    task automatic wait_idle(input int max);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (step_done && sb_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Count negedges after the push until step_done rises
    task automatic done_latency(input string name, input int vld2, input int exp);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) check({name, "_vld_n1"}, int'(syn_vld), 0);
            if (i == 2) check({name, "_vld_n2"}, int'(syn_vld), vld2);
            if (step_done) begin
                n = i;
                break;
            end
        end
        check({name, "_done_lat"}, n, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t expected finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        enable     = 1'b1;
        syn_rdy    = '1;
        syn_in_vld = 1'b0;
        syn_start  = '0;
        syn_end    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_vld", int'(syn_vld), 0);
        check("rst_addr", int'(syn_addr != '0), 0);
        check("rst_err", int'(range_err), 0);
        check("rst_done", int'(step_done), 1);
        check("rst_in_rdy", int'(syn_in_rdy), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_rdy", int'(syn_in_rdy), 1);
        @(posedge clk);
        #1;

        // 1: single-lane range 0..3
        push_range(0, 3);
        done_latency("t1", 1, 6);

        // 2: range straddling lane0/lane1
        push_range(1020, 1027);
        done_latency("t2", 3, 6);

        // 3a: back-to-back reload in lane0 with no bubble
        push_range(5, 6);
        push_range(7, 8);
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            check("t3_vld", int'(syn_vld[0]), 1);
            check("t3_addr", lane_addr(0), 5 + m);
        end
        wait_idle(20);

        // 3b: toggling ready on lane0
        syn_rdy     = 4'b1110;
        xfer_cnt[0] = 0;
        push_range(5, 6);
        push_range(7, 8);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            syn_rdy[0] = ~syn_rdy[0];
            @(negedge clk);
            if (step_done && sb_empty()) break;
        end
        syn_rdy = '1;
        check("t3_xfers", xfer_cnt[0], 4);
        wait_idle(20);

        // 4: stalled lane2 fills the queue, then drains in order
        syn_rdy = 4'b1011;
        push_range(2048, 2050);
        push_range(2051, 2052);
        push_range(2053, 2053);
        push_range(2060, 2062);
        push_range(2100, 2101);
        @(negedge clk);
        check("t4_full_rdy", int'(syn_in_rdy), 0);
        check("t4_done", int'(step_done), 0);
        check("t4_vld", int'(syn_vld), 4);
        check("t4_addr", lane_addr(2), 0);
        @(posedge clk);
        #1;
        syn_rdy = '1;
        wait_idle(40);

        // 5: malformed range is dropped with a one-cycle error pulse
        push_range(10, 9);
        @(negedge clk);
        check("t5_err_n1", int'(range_err), 0);
        @(negedge clk);
        check("t5_err_n2", int'(range_err), 1);
        check("t5_done_n2", int'(step_done), 1);
        check("t5_vld_n2", int'(syn_vld), 0);
        @(negedge clk);
        check("t5_err_n3", int'(range_err), 0);
        check("t5_done_n3", int'(step_done), 1);
        check("t5_vld_n3", int'(syn_vld), 0);
        @(posedge clk);
        #1;

        // 6a: reset during the second address of 0..7
        push_range(0, 7);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("t6_addr_before_rst", lane_addr(0), 1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_rst_vld", int'(syn_vld), 0);
        check("t6_rst_done", int'(step_done), 1);
        for (int k = 0; k < NL; k++) exp_q[k].delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("t6_in_rdy", int'(syn_in_rdy), 1);
        check("t6_done", int'(step_done), 1);
        check("t6_vld_idle", int'(syn_vld), 0);
        @(posedge clk);
        #1;

        // 6b: enable dropped mid-range freezes the iterator
        push_range(0, 5);
        repeat (3) @(posedge clk);
        #1;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_en_vld", int'(syn_vld), 0);
            check("t6_en_addr", lane_addr(0), 2);
            check("t6_en_done", int'(step_done), 0);
        end
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(negedge clk);
        check("t6_resume_vld", int'(syn_vld), 1);
        check("t6_resume_addr", lane_addr(0), 2);
        wait_idle(20);

        for (int k = 0; k < NL; k++)
            check($sformatf("sb_left_l%0d", k), exp_q[k].size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
